// File: rtl/pp_mem_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory arbiter.
package pp_arb_pkg;

    // Address and data width of every bus in the arbiter.
    localparam int XLEN = 32;

    // Consecutive data grants tolerated while a fetch is waiting.
    localparam logic [1:0] STARVE_MAX = 2'd3;

    // Count at which an outstanding memory access is abandoned.
    localparam logic [3:0] TMO_MAX = 4'd15;

    // Arbiter states with fixed encodings.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IACC = 2'b01,
        DACC = 2'b10
    } arb_state_t;

endpackage : pp_arb_pkg

// File: rtl/pp_mem_arbiter_if.sv
// Bus bundle between the pipeline (fetch and data ports), the arbiter and
// the single-port memory.
interface pp_mem_arbiter_if;
    import pp_arb_pkg::*;

    // fetch port
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_rdy;
    logic [XLEN-1:0] i_data;

    // data port
    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_rdy;
    logic [XLEN-1:0] d_data;

    // pipeline control
    logic            flush;

    // memory side
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;

    // status
    logic            err;

    // Arbiter view: serves the pipeline, drives the memory.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, flush,
        input  mem_rdata, mem_ready,
        output i_rdy, i_data, d_rdy, d_data,
        output mem_req, mem_we, mem_addr, mem_wdata, err
    );

    // Environment view: pipeline requester plus memory model.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, flush,
        output mem_rdata, mem_ready,
        input  i_rdy, i_data, d_rdy, d_data,
        input  mem_req, mem_we, mem_addr, mem_wdata, err
    );

endinterface : pp_mem_arbiter_if

// File: rtl/pp_mem_arbiter_timer.sv
// Access timeout counter: cleared on each grant, counts while an access is
// outstanding, flags the cycle in which the count reaches TMO_MAX.
module pp_arb_timer
    import pp_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TMO_MAX)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count steps onto TMO_MAX at the end of this cycle.
    assign expire_o = en_i && (cnt_q == (TMO_MAX - 4'd1));

endmodule : pp_arb_timer

// File: rtl/pp_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// data accesses. Data has priority, with a starvation guard for fetches,
// fetch cancellation on flush, and a sticky timeout error.
module pp_mem_arbiter
    import pp_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    pp_mem_arbiter_if.slave bus
);

    arb_state_t      state_q, state_d;
    logic [1:0]      starve_q, starve_d;
    logic            discard_q, discard_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            we_q, we_d;

    logic            grant_i;
    logic            grant_d;
    logic            force_i;
    logic            tmo_en;
    logic            tmo_expire;

    // A fetch that has lost STARVE_MAX data grants in a row takes the next slot.
    assign force_i = bus.i_req && !bus.flush && (starve_q == STARVE_MAX);
    assign tmo_en  = (state_q != IDLE);

    pp_arb_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (grant_i || grant_d),
        .en_i     (tmo_en),
        .expire_o (tmo_expire)
    );

    // Next-state, grant decision and latch values.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        discard_d = discard_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;

        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (!bus.i_req) begin
                    starve_d = '0;
                end

                if (force_i) begin
                    grant_i = 1'b1;
                end else if (bus.d_req) begin
                    grant_d = 1'b1;
                    if (bus.i_req && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 2'd1;
                    end
                end else if (bus.i_req && !bus.flush) begin
                    grant_i = 1'b1;
                end

                if (grant_i) begin
                    state_d  = IACC;
                    starve_d = '0;
                    addr_d   = bus.i_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                end else if (grant_d) begin
                    state_d  = DACC;
                    addr_d   = bus.d_addr;
                    we_d     = bus.d_we;
                    wdata_d  = bus.d_wdata;
                end
            end

            IACC: begin
                if (bus.flush) begin
                    discard_d = 1'b1;
                end
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end else if (tmo_expire) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    err_d     = 1'b1;
                end
            end

            DACC: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                end else if (tmo_expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                discard_d = 1'b0;
            end
        endcase
    end

    // FSM and control flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            discard_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            discard_q <= discard_d;
            err_q     <= err_d;
        end
    end

    // Access latch: the memory bus is driven only from these registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign bus.mem_req   = (state_q != IDLE);
    assign bus.mem_we    = we_q && (state_q == DACC);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // A flush arriving together with the completion still cancels the fetch.
    assign bus.i_rdy  = (state_q == IACC) && bus.mem_ready && !discard_q && !bus.flush;
    assign bus.d_rdy  = (state_q == DACC) && bus.mem_ready;
    assign bus.i_data = bus.i_rdy ? bus.mem_rdata : '0;
    assign bus.d_data = bus.d_rdy ? bus.mem_rdata : '0;
    assign bus.err    = err_q;

endmodule : pp_mem_arbiter

// File: tb/tb_pp_mem_arbiter.sv
// Directed bench for pp_mem_arbiter: cycle-by-cycle vector table followed
// by hand-written timeout and reset sequences.
module tb_pp_mem_arbiter;
    import pp_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pp_mem_arbiter_if bus ();

    pp_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        flush;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_irdy;
        logic        e_drdy;
        logic [31:0] e_data;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd, input logic fl,
                       input logic mr, input logic [31:0] md,
                       input logic er, input logic ew, input logic [31:0] ea,
                       input logic [31:0] ewd, input logic eir, input logic edr,
                       input logic [31:0] ed);
        vq.push_back('{ir, ia, dr, dw, da, dwd, fl, mr, md, er, ew, ea, ewd, eir, edr, ed});
    endtask

    task automatic drive_idle();
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();

        // fetch only, then ready in IDLE ignored
        add(1,'h100,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        add(1,'h100,0,0,0,0,0,1,'h2002000A, 1,0,'h100,0,1,0,'h2002000A);
        add(0,0,0,0,0,0,0,1,'hDEAD,         0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,0,0,0,              0,0,0,0,0,0,0);
        // collision: store first, then the waiting fetch
        add(1,'h200,1,1,'h40,'h55,0,0,0,    0,0,0,0,0,0,0);
        add(1,'h200,1,1,'h40,'h55,0,1,'hFFFF, 1,1,'h40,'h55,0,1,0);
        add(1,'h200,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        add(1,'h200,0,0,0,0,0,1,'h1234,     1,0,'h200,0,1,0,'h1234);
        add(0,0,0,0,0,0,0,0,0,              0,0,0,0,0,0,0);
        // starvation: three loads, then the fetch is forced through
        add(1,'h300,1,0,'h80,0,0,1,'hD0,    0,0,0,0,0,0,0);
        add(1,'h300,1,0,'h80,0,0,1,'hD0,    1,0,'h80,0,0,1,'hD0);
        add(1,'h300,1,0,'h80,0,0,1,'hD1,    0,0,0,0,0,0,0);
        add(1,'h300,1,0,'h80,0,0,1,'hD1,    1,0,'h80,0,0,1,'hD1);
        add(1,'h300,1,0,'h80,0,0,1,'hD2,    0,0,0,0,0,0,0);
        add(1,'h300,1,0,'h80,0,0,1,'hD2,    1,0,'h80,0,0,1,'hD2);
        add(1,'h300,1,0,'h80,0,0,1,'hD3,    0,0,0,0,0,0,0);
        add(1,'h300,1,0,'h80,0,0,1,'hF00D,  1,0,'h300,0,1,0,'hF00D);
        add(0,0,0,0,0,0,0,0,0,              0,0,0,0,0,0,0);
        // flush in the 2nd IACC cycle, ready in the 3rd
        add(1,'h400,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        add(1,'h400,0,0,0,0,0,0,0,          1,0,'h400,0,0,0,0);
        add(1,'h400,0,0,0,0,1,0,0,          1,0,'h400,0,0,0,0);
        add(1,'h500,0,0,0,0,0,1,'hBAD,      1,0,'h400,0,0,0,0);
        add(1,'h500,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        add(1,'h500,0,0,0,0,0,1,'h600D,     1,0,'h500,0,1,0,'h600D);
        add(0,0,0,0,0,0,0,0,0,              0,0,0,0,0,0,0);
        // flush in IDLE blocks the grant; flush with ready discards
        add(1,'h700,0,0,0,0,1,0,0,          0,0,0,0,0,0,0);
        add(1,'h700,0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
        add(1,'h700,0,0,0,0,1,1,'h77,       1,0,'h700,0,0,0,0);
        add(0,0,0,0,0,0,0,0,0,              0,0,0,0,0,0,0);
        // flush does not affect a data access
        add(0,0,1,0,'h44,0,0,0,0,           0,0,0,0,0,0,0);
        add(0,0,1,0,'h44,0,1,1,'h99,        1,0,'h44,0,0,1,'h99);
        add(0,0,0,0,0,0,0,0,0,              0,0,0,0,0,0,0);

        // reset state, with requests and ready active
        bus.i_req     = 1'b1;
        bus.d_req     = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_req",   32'(bus.mem_req), 32'd0);
        check("rst_mem_we",    32'(bus.mem_we), 32'd0);
        check("rst_mem_addr",  bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_i_rdy",     32'(bus.i_rdy), 32'd0);
        check("rst_d_rdy",     32'(bus.d_rdy), 32'd0);
        check("rst_err",       32'(bus.err), 32'd0);
        drive_idle();
        rst = 1'b0;

        // vector table
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            bus.i_req     = vq[i].i_req;
            bus.i_addr    = vq[i].i_addr;
            bus.d_req     = vq[i].d_req;
            bus.d_we      = vq[i].d_we;
            bus.d_addr    = vq[i].d_addr;
            bus.d_wdata   = vq[i].d_wdata;
            bus.flush     = vq[i].flush;
            bus.mem_ready = vq[i].mem_ready;
            bus.mem_rdata = vq[i].mem_rdata;
            #1;
            check($sformatf("v%0d_mem_req", i), 32'(bus.mem_req), 32'(vq[i].e_req));
            check($sformatf("v%0d_mem_we", i),  32'(bus.mem_we),  32'(vq[i].e_we));
            check($sformatf("v%0d_i_rdy", i),   32'(bus.i_rdy),   32'(vq[i].e_irdy));
            check($sformatf("v%0d_d_rdy", i),   32'(bus.d_rdy),   32'(vq[i].e_drdy));
            check($sformatf("v%0d_err", i),     32'(bus.err),     32'd0);
            if (vq[i].e_req) begin
                check($sformatf("v%0d_mem_addr", i),  bus.mem_addr,  vq[i].e_addr);
                check($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vq[i].e_wdata);
            end
            if (vq[i].e_irdy) begin
                check($sformatf("v%0d_i_data", i), bus.i_data, vq[i].e_data);
            end
            if (vq[i].e_drdy && !vq[i].d_we) begin
                check($sformatf("v%0d_d_data", i), bus.d_data, vq[i].e_data);
            end
        end

        // timeout: store that never sees mem_ready
        @(negedge clk);
        drive_idle();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h88;
        bus.d_wdata = 32'h12;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check($sformatf("tmo_c%0d_mem_req", k), 32'(bus.mem_req), 32'd1);
            check($sformatf("tmo_c%0d_err", k),     32'(bus.err), 32'd0);
            check($sformatf("tmo_c%0d_d_rdy", k),   32'(bus.d_rdy), 32'd0);
        end
        @(negedge clk);
        check("tmo_err_set",   32'(bus.err), 32'd1);
        check("tmo_mem_req",   32'(bus.mem_req), 32'd0);
        check("tmo_state",     32'(dut.state_q), 32'(IDLE));
        check("tmo_d_rdy",     32'(bus.d_rdy), 32'd0);
        drive_idle();

        // err stays set across a later fetch
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h10;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0BADF00D;
        #1;
        check("sticky_i_rdy",  32'(bus.i_rdy), 32'd1);
        check("sticky_i_data", bus.i_data, 32'h0BADF00D);
        check("sticky_err",    32'(bus.err), 32'd1);
        @(negedge clk);
        drive_idle();

        // reset asserted asynchronously in the middle of a store
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h90;
        bus.d_wdata = 32'hAB;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h104;
        @(negedge clk);
        check("mid_mem_req", 32'(bus.mem_req), 32'd1);
        check("mid_mem_we",  32'(bus.mem_we), 32'd1);
        bus.mem_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_mem_req",   32'(bus.mem_req), 32'd0);
        check("arst_mem_we",    32'(bus.mem_we), 32'd0);
        check("arst_mem_addr",  bus.mem_addr, 32'd0);
        check("arst_mem_wdata", bus.mem_wdata, 32'd0);
        check("arst_d_rdy",     32'(bus.d_rdy), 32'd0);
        check("arst_err",       32'(bus.err), 32'd0);
        check("arst_state",     32'(dut.state_q), 32'(IDLE));
        check("arst_tmo_cnt",   32'(dut.u_timer.cnt_q), 32'd0);
        check("arst_starve",    32'(dut.starve_q), 32'd0);
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // first grant on the first edge after reset release
        @(negedge clk);
        check("post_rst_mem_req",  32'(bus.mem_req), 32'd1);
        check("post_rst_mem_addr", bus.mem_addr, 32'h104);
        check("post_rst_mem_we",   32'(bus.mem_we), 32'd0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFE;
        #1;
        check("post_rst_i_rdy",  32'(bus.i_rdy), 32'd1);
        check("post_rst_i_data", bus.i_data, 32'hCAFE);
        @(negedge clk);
        drive_idle();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pp_mem_arbiter

// File: doc/pp_mem_arbiter.md
PP_MEM_ARBITER -- requirements
Module: pp_mem_arbiter

Interface
REQ-001 clock  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 i_req  in  1  fetch request from IF stage; held until i_rdy or flush.
REQ-004 i_addr  in  32  fetch word address.
REQ-005 i_rdy  out  1  fetch complete this cycle; i_data valid this cycle only.
REQ-006 i_data  out  32  fetched instruction.
REQ-007 d_req  in  1  data request from MEM stage (lw/sw); held until d_rdy.
REQ-008 d_we  in  1  1 = store (sw), 0 = load (lw).
REQ-009 d_addr  in  32  data address.
REQ-010 d_wdata  in  32  store data.
REQ-011 d_rdy  out  1  data access complete this cycle.
REQ-012 d_data  out  32  load data; valid with d_rdy when d_we=0.
REQ-013 flush  in  1  taken branch/jump; cancels the pending or in-flight fetch.
REQ-014 mem_req  out  1  request to the single-port memory.
REQ-015 mem_we  out  1  memory write enable.
REQ-016 mem_addr  out  32  memory address.
REQ-017 mem_wdata  out  32  memory write data.
REQ-018 mem_rdata  in  32  memory read data; valid when mem_ready=1.
REQ-019 mem_ready  in  1  memory completes the current access this cycle; latency 1..n cycles.
REQ-020 err  out  1  sticky memory-timeout flag.

Function
REQ-021 FSM states: IDLE, IACC, DACC, each with a fixed encoding.
REQ-022 In IDLE, grant order: d_req goes to DACC; else i_req & ~flush goes to IACC; else stay in IDLE.
REQ-023 Starvation guard: when d_req has won STARVE_MAX=3 consecutive IDLE grants while i_req was pending, the next grant goes to IACC.
REQ-024 The starvation counter clears on any I grant or when i_req=0 in IDLE.
REQ-025 On each grant, address, we and wdata are latched into internal registers; mem_* outputs drive only from these registers; mem_we=0 in IACC.
REQ-026 mem_req=1 in IACC and DACC; mem_req=0 in IDLE.
REQ-027 Completion is a cycle with mem_ready=1 in IACC or DACC; on completion the FSM returns to IDLE.
REQ-028 d_rdy=(DACC & mem_ready); d_data=mem_rdata on that cycle.
REQ-029 i_rdy=(IACC & mem_ready & ~discard); i_data=mem_rdata on that cycle.
REQ-030 Minimum latency: request sampled in IDLE at cycle N, rdy at cycle N+1; each access costs at least 2 cycles, including the IDLE cycle.
REQ-031 Flush in IACC sets the discard flag; the memory access still completes without i_rdy; discard clears on return to IDLE.
REQ-032 Flush in IDLE with only i_req pending: no grant that cycle. Flush has no effect on DACC.
REQ-033 Flush and mem_ready in the same IACC cycle: i_rdy=0 (the fetch is discarded).
REQ-034 Timeout: a 4-bit counter runs in IACC/DACC and clears on each grant.
REQ-035 If the timeout counter reaches 15 without mem_ready, err sets, the access is abandoned, the FSM returns to IDLE, and no rdy is asserted.
REQ-036 err stays set until reset.
REQ-037 mem_ready in IDLE is ignored.

Reset
REQ-038 Reset asserted: the FSM enters IDLE asynchronously; starvation counter, timeout counter, discard and err become 0; latched address/data registers become 0.
REQ-039 During reset: mem_req=0, mem_we=0, i_rdy=0, d_rdy=0, mem_addr=0, mem_wdata=0.
REQ-040 Reset during IACC/DACC abandons the access with no rdy asserted.
REQ-041 The first grant is possible in the first clock edge after reset deasserts.

Structure
REQ-042 Package pp_arb_pkg holds the FSM state encodings, STARVE_MAX=3, TMO_MAX=15 and the address/data width constant 32.
REQ-043 One sub-module, pp_arb_timer, implements the timeout counter (clear, enable, expire outputs); everything else lives in pp_mem_arbiter.

Verification
REQ-044 Fetch only: i_req=1, i_addr=0x100, mem_ready on the first IACC cycle with rdata=0x2002000A -> i_rdy 1 cycle later, i_data=0x2002000A, mem_we=0.
REQ-045 Collision: i_req=1 and d_req=1 (sw, addr 0x40, wdata 0x55) in the same IDLE cycle -> DACC first with mem_we=1, mem_addr=0x40; IACC follows after d_rdy.
REQ-046 Starvation: i_req held, d_req re-asserted continuously, mem_ready latency 1 -> after 3 D grants the 4th grant is IACC and i_rdy asserts.
REQ-047 Flush: flush pulsed in the 2nd IACC cycle, mem_ready in the 3rd -> i_rdy stays 0; the FSM returns to IDLE; a new i_req is granted in the next cycle.
REQ-048 Timeout: DACC with mem_ready held 0 -> after 15 cycles err=1 and the FSM is in IDLE, d_rdy never asserts; err stays 1 until reset.
REQ-049 Reset mid-access: reset asserted asynchronously in DACC -> mem_req=0 immediately, state IDLE, counters 0.
